ram_wb_arbiter: RTL and testbench

- Two-master Wishbone (classic, single-beat) arbiter in front of the 4002-style RAM's Wishbone backdoor port.
- Shares that port between the host debug master (m0) and the loader/DMA master (m1) with round-robin fairness.
- Holds the grant until the RAM acks, and returns an error on timeout, because the RAM acks only once per 8-clock bus cycle.
- Sits between the SoC interconnect and the RAM's wb_* ports.

---
 rtl/ram_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_wb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the RAM's single-beat
// backdoor port; holds the grant until the RAM acks, errors on timeout.
module ram_wb_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic [1:0]  state_o
);

    // Handshake: a master requests while cyc&stb are high and must hold its
    // request stable until it sees a one-clock ack or err; dropping cyc
    // earlier aborts the cycle. The slave side is a classic single beat:
    // cyc/stb stay high until the RAM answers with a one-clock s_ack_i.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic             last;
    logic             owner;
    logic [CNT_W-1:0] cnt;

    logic m0_req;
    logic m1_req;
    logic pick;
    logic owner_cyc;
    logic timeout_hit;

    assign m0_req      = m0_cyc_i & m0_stb_i;
    assign m1_req      = m1_cyc_i & m1_stb_i;
    // On contention the master that was not served last wins.
    assign pick        = (m0_req & m1_req) ? ~last : m1_req;
    assign owner_cyc   = owner ? m1_cyc_i : m0_cyc_i;
    assign timeout_hit = (cnt == CNT_LAST);

    assign busy_o  = (state != IDLE);
    assign state_o = state;

    // Slave side is combinational so an abort drops cyc/stb in the same clock.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        if (state == ACTIVE) begin
            s_cyc_o  = owner_cyc;
            s_stb_o  = owner_cyc;
            s_we_o   = owner ? m1_we_i   : m0_we_i;
            s_addr_o = owner ? m1_addr_i : m0_addr_i;
            s_data_o = owner ? m1_data_i : m0_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            cnt       <= '0;
            grant_o   <= 2'b00;
            m0_data_o <= '0;
            m1_data_o <= '0;
            m0_ack_o  <= 1'b0;
            m1_ack_o  <= 1'b0;
            m0_err_o  <= 1'b0;
            m1_err_o  <= 1'b0;
        end else begin
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner   <= pick;
                        grant_o <= pick ? 2'b10 : 2'b01;
                        cnt     <= '0;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!owner_cyc) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                        last    <= owner;
                    end else if (s_ack_i) begin
                        // RAM returns pre-write data, so writes capture it too.
                        if (owner) begin
                            m1_data_o <= s_data_i;
                            m1_ack_o  <= 1'b1;
                        end else begin
                            m0_data_o <= s_data_i;
                            m0_ack_o  <= 1'b1;
                        end
                        state <= RESP;
                    end else if (timeout_hit) begin
                        if (owner) begin
                            m1_err_o <= 1'b1;
                        end else begin
                            m0_err_o <= 1'b1;
                        end
                        state <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                    last    <= owner;
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Scoreboard bench for ram_wb_arbiter with a behavioural 4-bit RAM slave
// that acks a fixed number of clocks after it sees cyc/stb.
module tb_ram_wb_arbiter;

    logic        clock;
    logic        reset_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] exp0_q[$];
    logic [33:0] exp1_q[$];
    logic [1:0]  exp_grant_q[$];

    logic [3:0]  mem [0:255];
    bit          ack_enable;
    int          ack_delay;
    int          inject_req;

    ram_wb_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .state_o   (state_o)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [33:0] mk_ack(input logic [31:0] d);
        return {2'b10, d};
    endfunction

    function automatic logic [33:0] mk_err(input logic [31:0] d);
        return {2'b01, d};
    endfunction

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_cyc_i = req; m0_stb_i = req; m0_we_i = we;
            m0_addr_i = addr; m0_data_i = wdata;
        end else begin
            m1_cyc_i = req; m1_stb_i = req; m1_we_i = we;
            m1_addr_i = addr; m1_data_i = wdata;
        end
    endtask

    // One master transaction: push the expected response, request, wait
    // (bounded) for ack/err, then release. lat counts clocks from request.
    task automatic master_txn(input int m, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [33:0] exp,
                              output int lat);
        bit done;
        if (m == 0) exp0_q.push_back(exp);
        else exp1_q.push_back(exp);
        @(negedge clock);
        drive(m, 1'b1, we, addr, wdata);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
            done = (m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o);
        end
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        check($sformatf("txn_done_m%0d", m), done, 1'b1);
    endtask

    task automatic check_resp(input int m, input logic ack, input logic err,
                              input logic [31:0] data);
        logic [33:0] e;
        if (ack || err) begin
            check($sformatf("ack_err_exclusive_m%0d", m), ack & err, 1'b0);
            if (m == 0 && exp0_q.size() == 0)
                check("unexpected_resp_m0", {ack, err}, 2'b00);
            else if (m == 1 && exp1_q.size() == 0)
                check("unexpected_resp_m1", {ack, err}, 2'b00);
            else begin
                e = (m == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                check($sformatf("resp_m%0d", m), {ack, err, data}, e);
            end
        end
    endtask

    // ---------------- RAM slave model ----------------
    initial begin : ram_model
        bit busy;
        int cnt;
        int inject_seen;
        busy = 1'b0;
        cnt = 0;
        inject_seen = 0;
        s_ack_i = 1'b0;
        s_data_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        mem[5] = 4'hA;
        forever begin
            @(negedge clock);
            s_ack_i  = 1'b0;
            s_data_i = '0;
            if (busy && !s_cyc_o) busy = 1'b0;
            if (inject_req != inject_seen) begin
                inject_seen = inject_req;
                s_ack_i  = 1'b1;
                s_data_i = 32'hDEAD_BEEF;
            end else if (busy) begin
                if (cnt == 0) begin
                    s_ack_i  = 1'b1;
                    s_data_i = {28'h0, mem[s_addr_o[7:0]]};
                    if (s_we_o) mem[s_addr_o[7:0]] = s_data_o[3:0];
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (s_cyc_o && s_stb_o && ack_enable) begin
                busy = 1'b1;
                cnt  = ack_delay - 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [1:0] prev_grant;
        prev_grant = 2'b00;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check_resp(0, m0_ack_o, m0_err_o, m0_data_o);
                check_resp(1, m1_ack_o, m1_err_o, m1_data_o);
                if (grant_o != 2'b00 && prev_grant == 2'b00) begin
                    if (exp_grant_q.size() == 0) check("unexpected_grant", grant_o, 2'b00);
                    else check("grant_order", grant_o, exp_grant_q.pop_front());
                end
            end
            prev_grant = grant_o;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int lat0, lat1;
        ack_enable = 1'b1;
        ack_delay  = 8;
        inject_req = 0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check("rst_grant", grant_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_state", state_o, 2'd0);
        check("rst_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check("rst_acks_errs", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
        check("rst_m0_data", m0_data_o, 32'h0);
        check("rst_m1_data", m1_data_o, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Single read of preloaded word 5.
        exp_grant_q.push_back(2'b01);
        master_txn(0, 1'b0, 32'h5, 32'h0, mk_ack(32'h0000_000A), lat0);
        check("t1_latency_le_11", lat0 <= 11, 1'b1);
        @(negedge clock);
        check("t1_grant_idle", grant_o, 2'b00);

        // m1 write 3 to 0x42 (pre-write data 0), then read back.
        exp_grant_q.push_back(2'b10);
        master_txn(1, 1'b1, 32'h42, 32'h3, mk_ack(32'h0), lat1);
        exp_grant_q.push_back(2'b10);
        master_txn(1, 1'b0, 32'h42, 32'h0, mk_ack(32'h3), lat1);

        // Both masters contend for three transactions each.
        for (int i = 0; i < 3; i++) begin
            exp_grant_q.push_back(2'b01);
            exp_grant_q.push_back(2'b10);
        end
        fork
            begin
                for (int i = 0; i < 3; i++)
                    master_txn(0, 1'b0, 32'h5, 32'h0, mk_ack(32'hA), lat0);
            end
            begin
                for (int i = 0; i < 3; i++)
                    master_txn(1, 1'b0, 32'h42, 32'h0, mk_ack(32'h3), lat1);
            end
        join

        // RAM never acks: err 16 clocks after ACTIVE entry, data kept.
        ack_enable = 1'b0;
        exp_grant_q.push_back(2'b01);
        master_txn(0, 1'b0, 32'h5, 32'h0, mk_err(32'hA), lat0);
        check("t4_err_after_16", lat0, 17);
        @(negedge clock);
        check("t4_busy_idle", busy_o, 1'b0);
        check("t4_state_idle", state_o, 2'd0);
        ack_enable = 1'b1;

        // Abort: m1 drops cyc in ACTIVE, late ack in IDLE, m0 then served.
        exp_grant_q.push_back(2'b10);
        exp_grant_q.push_back(2'b01);
        @(negedge clock);
        drive(1, 1'b1, 1'b0, 32'h42, 32'h0);
        @(negedge clock);
        check("t5_m1_granted", grant_o, 2'b10);
        fork
            master_txn(0, 1'b0, 32'h5, 32'h0, mk_ack(32'hA), lat0);
            begin
                repeat (2) @(negedge clock);
                check("t5_s_cyc_before_abort", {s_cyc_o, s_stb_o}, 2'b11);
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
                #1;
                check("t5_s_cyc_falls", {s_cyc_o, s_stb_o}, 2'b00);
                @(posedge clock);
                #1;
                check("t5_idle_after_abort", busy_o, 1'b0);
                inject_req++;
            end
        join

        // Reset mid-ACTIVE, then m0 must win the first contention.
        exp_grant_q.push_back(2'b01);
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 32'h5, 32'h0);
        repeat (2) @(negedge clock);
        check("t6_active_before_rst", busy_o, 1'b1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_grant", grant_o, 2'b00);
        check("t6_rst_busy", busy_o, 1'b0);
        check("t6_rst_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check("t6_rst_s_addr", s_addr_o, 32'h0);
        check("t6_rst_m0_data", m0_data_o, 32'h0);
        check("t6_rst_m1_data", m1_data_o, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        fork
            master_txn(0, 1'b0, 32'h5, 32'h0, mk_ack(32'hA), lat0);
            master_txn(1, 1'b0, 32'h42, 32'h0, mk_ack(32'h3), lat1);
        join

        repeat (3) @(negedge clock);
        check("end_exp0_drained", exp0_q.size(), 0);
        check("end_exp1_drained", exp1_q.size(), 0);
        check("end_grants_drained", exp_grant_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
